// File: rtl/mc_cpu_pkg.sv
// Shared types and instruction-field layout for the multi-cycle core.
package mc_cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;
  localparam int OP_LO   = 12;
  localparam int RD_LO   = 8;
  localparam int RS1_LO  = 4;
  localparam int RS2_LO  = 0;
  localparam int IMM_LO  = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_ADD  = 4'h6,
    OP_SUB  = 4'h7,
    OP_BNZ  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_e;

  function automatic logic writes_reg(logic [3:0] op);
    return op inside {[4'h1:4'h7]};
  endfunction

  function automatic logic is_illegal(logic [3:0] op);
    return op inside {[4'h9:4'hE]};
  endfunction
endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: LDI pass-through of b, bitwise ops, modular add/sub.
module mc_alu import mc_cpu_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      OP_LDI:  result = b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle core: FETCH -> DECODE -> EXEC -> WB with a wait-state fetch
// handshake, reset-cleared register file and a combinational debug read port.
module mc_cpu_core import mc_cpu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               halted,
  output logic               retire,
  output logic               illegal,
  output logic [PC_W-1:0]    dbg_pc,
  input  logic [RW-1:0]      dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
);
  state_e              state;
  logic [PC_W-1:0]     pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   a, b, result, alu_y;
  opcode_e             op;
  logic [RW-1:0]       rd, rs1, rs2;
  logic [PC_W-1:0]     target;
  logic [DATA_W-1:0]   imm;

  // Register fields keep only the low bits needed to address NREGS.
  assign op     = opcode_e'(ir[OP_LO +: FIELD_W]);
  assign rd     = RW'(ir[RD_LO  +: FIELD_W]);
  assign rs1    = RW'(ir[RS1_LO +: FIELD_W]);
  assign rs2    = RW'(ir[RS2_LO +: FIELD_W]);
  assign imm    = DATA_W'(ir[IMM_LO +: IMM_W]);
  assign target = PC_W'(ir[IMM_LO +: IMM_W]);

  assign imem_addr = pc;
  assign dbg_pc    = pc;
  assign dbg_rdata = regs[dbg_raddr];

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      result   <= '0;
      imem_req <= 1'b1;
      halted   <= 1'b0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_valid) begin
          ir       <= imem_rdata;
          pc       <= pc + PC_W'(1);
          imem_req <= 1'b0;
          state    <= S_DECODE;
        end
        S_DECODE: begin
          // BNZ tests the register named by the rd field.
          a      <= (op == OP_BNZ) ? regs[rd] : regs[rs1];
          b      <= (op == OP_LDI) ? imm : regs[rs2];
          if (is_illegal(op)) illegal <= 1'b1;
          retire <= !writes_reg(op);
          state  <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_y;
          if (writes_reg(op)) begin
            retire <= 1'b1;
            state  <= S_WB;
          end else begin
            retire <= 1'b0;
            if (op == OP_HALT) begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end else begin
              if (op == OP_BNZ && a != '0) pc <= target;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          regs[rd] <= result;
          retire   <= 1'b0;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        default: begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
      endcase
    end
  end
endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multi-cycle CPU core: fetches 16-bit instructions over a valid/request handshake from an external instruction memory, decodes them, executes logic/arithmetic/immediate/branch operations on a parametrised register file, and halts on a HALT instruction. It supersedes the fixed 8-bit, 8-register, AND/OR/XOR/NOT-only core. Data width, register count and PC width are generic. It adds a wait-state fetch handshake, ADD/SUB, immediate load, conditional branch, halt, and a debug read port for verification.

## Interface
- DATA_W, 8: register/ALU width; must be ≥ 8.
- NREGS, 8: register count; power of two, 2..16.
- PC_W, 4: PC/instruction address width.
- Clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request; high exactly while state = FETCH.
- imem_addr  out  PC_W  fetch address; equals PC; stable while imem_req is high.
- imem_valid  in  1  instruction valid; sampled only while imem_req is high.
- imem_rdata  in  16  instruction word; captured when imem_req && imem_valid.
- halted  out  1  high in HALTED state.
- retire  out  1  one-cycle pulse when an instruction completes (WB, or EXEC for branch/NOP/HALT).
- illegal  out  1  sticky; set on an undefined opcode; cleared only by rst.
- dbg_pc  out  PC_W  current PC.
- dbg_raddr  in  clog2(NREGS)  debug register select.
- dbg_rdata  out  DATA_W  combinational read of regs[dbg_raddr].

## Operation
- Instruction fields: op = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0], imm8 = [7:0]. Register fields use their low clog2(NREGS) bits; upper bits are ignored.
- Opcodes:
  - 0 NOP
  - 1 LDI: rd ← zero-extended imm8
  - 2 AND, 3 OR, 4 XOR: rd ← rs1 op rs2
  - 5 NOT: rd ← ~rs1
  - 6 ADD, 7 SUB: modulo 2^DATA_W; carry/borrow discarded
  - 8 BNZ: if regs[rs1≡rd field] ≠ 0, PC ← imm8[PC_W-1:0]. BNZ uses rd field [11:8] as the tested register.
  - F HALT
  - 9–E: illegal; set the `illegal` flag and execute as NOP.
- States: FETCH → DECODE → EXEC → WB → FETCH.
  - FETCH: holds until imem_valid. On the capture edge, IR ← imem_rdata and PC ← PC+1, wrapping at 2^PC_W.
  - DECODE: operands are read into the A/B latches.
  - EXEC: the ALU result is latched. BNZ, NOP, illegal opcodes and HALT skip WB.
    - Taken BNZ: PC ← target, then FETCH.
    - HALT: → HALTED.
  - WB: regs[rd] ← result, then FETCH.
  - HALTED: terminal; only rst exits.
- No forwarding is needed; execution is strictly sequential.
- All registers, including r0, are writable.
- The core ignores imem_valid outside FETCH.

## Timing
- rst edge: PC=0, IR=0, all regs=0, illegal=0, state=FETCH.
  - Outputs after the reset edge: imem_req=1, imem_addr=0, halted=0, retire=0.
- Reset mid-operation (any state, including FETCH waiting or HALTED) abandons the instruction. The instruction memory shares rst, so no stale response is pending.
- Zero-wait memory (imem_valid high in the first FETCH cycle):
  - ALU/LDI: 4 cycles per instruction.
  - BNZ/NOP/HALT: 3 cycles.
- Each cycle with imem_valid low in FETCH adds one cycle.
- retire is asserted in the final cycle of each instruction. For HALT, retire and the transition to halted occur together: halted rises the cycle after retire.
- PC wrap: fetching at address 2^PC_W−1 continues at 0.
- Write-back and debug read of the same register in the WB cycle: dbg_rdata shows the old value; the new value is visible from the next cycle.

## Structure
- Package mc_cpu_pkg holds:
  - opcode enum
  - FSM state enum
  - instruction field bit positions
  - INSTR_W = 16
- Sub-module mc_alu: combinational, parametrised by DATA_W; inputs op, a, b; output result. It covers LDI pass-through, AND/OR/XOR/NOT and ADD/SUB.
- The register file lives inside the core as a reset-cleared array.

## Test plan
- Reset then LDI r1,0x5A; LDI r2,0x0F; AND r3,r1,r2; HALT with zero wait → r3=0x0A. retire pulses at cycles 4, 8, 12 and 15; halted=1 afterwards.
- DATA_W=8: LDI r1,0xFF; LDI r2,0x02; ADD r3,r1,r2; SUB r4,r2,r1 → r3=0x01, r4=0x03.
- Loop: LDI r1,3; LDI r2,1; SUB r1,r1,r2; BNZ r1,2; HALT → exactly 3 SUB retirements, final r1=0, PC at halt = 5.
- Random 0–5 imem_valid wait cycles on the first program → identical final registers; imem_addr is stable while imem_req is high.
- Opcode 0xA then LDI r1,7 → illegal=1 and stays set; r1=7; no register changes from the illegal word.
- rst asserted during WB of ADD → destination stays 0. Next cycle: imem_addr=0, illegal=0. PC_W=4 program of 16 NOPs wraps to address 0.
